fpu_arbiter: RTL and testbench

- Shares one fpu instance between NUM_REQ requesters with round-robin arbitration.
- Accepts one operation from the granted requester and drives the fpu input handshake.
- Waits for the result, then returns it to the same requester on a held valid/ack response channel.
- Exactly one operation is in flight at any time; a watchdog returns an error response if the fpu stalls.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_arbiter_rr_arbiter.sv | 31 +++
 rtl/fpu_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_fpu_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu and the units that share it.
// Holds the arbiter state encoding, command codes and float-format widths.
package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_RESPOND
    } arb_state_t;

    localparam logic [3:0] CMD_ADD = 4'h4;
    localparam logic [3:0] CMD_SUB = 4'h6;
    localparam logic [3:0] CMD_MUL = 4'h7;
    localparam logic [3:0] CMD_DIV = 4'h8;

    // IEEE-754 field widths for the operand width the fpu is built with
    function automatic int unsigned exp_width(input int unsigned width);
        case (width)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned mant_width(input int unsigned width);
        return width - exp_width(width) - 1;
    endfunction

endpackage

// File: rtl/fpu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Produces a one-hot grant and the winner index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               found
);

    int unsigned cand;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(ptr) + off) % NUM_REQ;
            if (!found && req[IDX_W'(cand)]) begin
                found              = 1'b1;
                index              = IDX_W'(cand);
                grant[IDX_W'(cand)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one fpu between NUM_REQ requesters: round-robin grant, single
// operation in flight, held response channel and a stall watchdog.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned bitness = 32,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*bitness-1:0] req_data_a,
    input  logic [NUM_REQ*bitness-1:0] req_data_b,
    input  logic [NUM_REQ*4-1:0]       req_command,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ack,
    output logic [bitness-1:0]         rsp_result,
    output logic                       rsp_error,
    output logic                       fpu_input_rdy,
    input  logic                       fpu_input_ack,
    input  logic                       fpu_output_rdy,
    output logic                       fpu_output_ack,
    output logic [bitness-1:0]         fpu_data_a,
    output logic [bitness-1:0]         fpu_data_b,
    output logic [3:0]                 fpu_command,
    input  logic [bitness-1:0]         fpu_result,
    output logic                       busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t          state;
    arb_state_t          next_state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic [WD_W-1:0]     watchdog;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    logic                wd_expired;
    logic                owner_ack;
    logic                abort;
    logic [NUM_REQ-1:0]  owner_onehot;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .index (win_idx),
        .found (win_found)
    );

    assign wd_expired   = (watchdog == WD_LAST);
    assign owner_ack    = rsp_ack[owner];
    assign owner_onehot = NUM_REQ'(1) << owner;
    assign busy         = (state != ST_IDLE);
    assign req_ready    = (state == ST_IDLE) ? grant : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A result sampled on the expiry cycle takes priority over the abort
    always_comb begin
        next_state = state;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fpu_input_ack) begin
                    next_state = ST_WAIT;
                end else if (wd_expired) begin
                    next_state = ST_RESPOND;
                    abort      = 1'b1;
                end
            end
            ST_WAIT: begin
                if (fpu_output_rdy) begin
                    next_state = ST_DRAIN;
                end else if (wd_expired) begin
                    next_state = ST_RESPOND;
                    abort      = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!fpu_output_rdy) begin
                    next_state = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (owner_ack) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr         <= '0;
            owner          <= '0;
            watchdog       <= '0;
            fpu_input_rdy  <= 1'b0;
            fpu_output_ack <= 1'b0;
            fpu_data_a     <= '0;
            fpu_data_b     <= '0;
            fpu_command    <= '0;
            rsp_valid      <= '0;
            rsp_result     <= '0;
            rsp_error      <= 1'b0;
        end else begin
            fpu_output_ack <= 1'b0;
            if (abort) begin
                fpu_input_rdy <= 1'b0;
                rsp_result    <= '0;
                rsp_error     <= 1'b1;
                rsp_valid     <= owner_onehot;
                watchdog      <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (win_found) begin
                            fpu_data_a    <= req_data_a[32'(win_idx) * bitness +: bitness];
                            fpu_data_b    <= req_data_b[32'(win_idx) * bitness +: bitness];
                            fpu_command   <= req_command[32'(win_idx) * 4 +: 4];
                            owner         <= win_idx;
                            rr_ptr        <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                            fpu_input_rdy <= 1'b1;
                            watchdog      <= '0;
                        end
                    end
                    ST_ISSUE: begin
                        if (fpu_input_ack) begin
                            fpu_input_rdy <= 1'b0;
                            watchdog      <= '0;
                        end else begin
                            watchdog <= watchdog + 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (fpu_output_rdy) begin
                            rsp_result     <= fpu_result;
                            rsp_error      <= 1'b0;
                            fpu_output_ack <= 1'b1;
                            watchdog       <= '0;
                        end else begin
                            watchdog <= watchdog + 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (!fpu_output_rdy) begin
                            rsp_valid <= owner_onehot;
                        end
                    end
                    ST_RESPOND: begin
                        if (owner_ack) begin
                            rsp_valid <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a behavioural fpu driven on the
// falling edge; expected grants and results are hand-computed constants.
module tb_fpu_arbiter;
    import fpu_pkg::*;

    localparam int unsigned BITS = 32;
    localparam int unsigned NREQ = 4;
    localparam int unsigned TMO  = 16;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*BITS-1:0]    req_data_a = '0;
    logic [NREQ*BITS-1:0]    req_data_b = '0;
    logic [NREQ*4-1:0]       req_command = '0;
    logic [NREQ-1:0]         rsp_valid;
    logic [NREQ-1:0]         rsp_ack = '0;
    logic [BITS-1:0]         rsp_result;
    logic                    rsp_error;
    logic                    fpu_input_rdy;
    logic                    fpu_input_ack = 1'b0;
    logic                    fpu_output_rdy = 1'b0;
    logic                    fpu_output_ack;
    logic [BITS-1:0]         fpu_data_a;
    logic [BITS-1:0]         fpu_data_b;
    logic [3:0]              fpu_command;
    logic [BITS-1:0]         fpu_result = '0;
    logic                    busy;

    always #5 clock = ~clock;

    fpu_arbiter #(.bitness(BITS), .NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data_a(req_data_a), .req_data_b(req_data_b), .req_command(req_command),
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .fpu_input_rdy(fpu_input_rdy), .fpu_input_ack(fpu_input_ack),
        .fpu_output_rdy(fpu_output_rdy), .fpu_output_ack(fpu_output_ack),
        .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b), .fpu_command(fpu_command),
        .fpu_result(fpu_result), .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stand-in fpu: one genuine IEEE sum (1.0+2.0), otherwise a cheap mixing function
    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
        if (c == CMD_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a ^ b ^ {28'h0, c};
    endfunction

    int   ack_enable  = 1;
    int   reply_delay = 1;
    int   sticky      = 0;
    logic model_flush = 1'b0;
    logic pending = 1'b0, holding = 1'b0;
    int   cnt = 0, hold_cnt = 0;
    logic [31:0] res = '0;

    always @(negedge clock) begin
        if (reset || model_flush) begin
            pending = 1'b0; holding = 1'b0;
            fpu_input_ack = 1'b0; fpu_output_rdy = 1'b0; fpu_result = '0;
        end else begin
            if (holding) begin
                hold_cnt--;
                if (hold_cnt == 0) begin fpu_output_rdy = 1'b0; holding = 1'b0; end
            end else if (fpu_output_rdy && fpu_output_ack) begin
                if (sticky == 0) fpu_output_rdy = 1'b0;
                else begin holding = 1'b1; hold_cnt = sticky; end
            end
            if (pending) begin
                if (cnt == 0) begin fpu_output_rdy = 1'b1; fpu_result = res; pending = 1'b0; end
                else cnt--;
            end
            if (fpu_input_ack) begin
                res = fpu_fn(fpu_data_a, fpu_data_b, fpu_command);
                pending = 1'b1; cnt = reply_delay; fpu_input_ack = 1'b0;
            end else if (fpu_input_rdy && ack_enable != 0 && !pending && !fpu_output_rdy) begin
                fpu_input_ack = 1'b1;
            end
        end
    end

    int oack_count = 0, irdy_count = 0, drain_viol = 0;
    always @(negedge clock) begin
        if (fpu_output_ack) oack_count++;
        if (fpu_input_rdy)  irdy_count++;
        if (fpu_output_rdy && (rsp_valid != '0 || fpu_input_rdy)) drain_viol++;
    end

    logic [3:0] cmds [NREQ] = '{CMD_ADD, CMD_SUB, CMD_MUL, CMD_DIV};

    task automatic set_data(input logic [31:0] b);
        for (int i = 0; i < NREQ; i++) begin
            req_data_a[i*BITS +: BITS] = 32'(i + 1) << 28;
            req_data_b[i*BITS +: BITS] = b;
            req_command[i*4 +: 4]      = cmds[i];
        end
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, " ctl"}, 64'({req_ready, rsp_valid, rsp_error, fpu_input_rdy,
                                   fpu_output_ack, fpu_command, busy}), 64'(0));
        check({name, " result"}, 64'(rsp_result), 64'(0));
        check({name, " data_a"}, 64'(fpu_data_a), 64'(0));
        check({name, " data_b"}, 64'(fpu_data_b), 64'(0));
    endtask

    // Called on a falling edge with the DUT idle
    task automatic run_op(input string name, input logic [3:0] mask, input logic [3:0] exp_grant,
                          input logic [31:0] exp_res, input logic exp_err, input int hold_ack);
        int   n;
        logic busy_bad, stable_bad;
        req_valid = mask;
        #1 check({name, " req_ready"}, 64'(req_ready), 64'(exp_grant));
        @(negedge clock);
        n = 0; busy_bad = 1'b0;
        while (rsp_valid == '0 && n < 200) begin
            if (req_ready != '0) busy_bad = 1'b1;
            @(negedge clock);
            n++;
        end
        check({name, " rsp_wait_expired"}, 64'(n >= 200), 64'(0));
        check({name, " rsp_valid"}, 64'(rsp_valid), 64'(exp_grant));
        check({name, " rsp_result"}, 64'(rsp_result), 64'(exp_res));
        check({name, " rsp_error"}, 64'(rsp_error), 64'(exp_err));
        check({name, " ready_while_busy"}, 64'(busy_bad), 64'(0));
        if (hold_ack > 0) begin
            stable_bad = 1'b0;
            rsp_ack = ~exp_grant;
            for (int k = 0; k < hold_ack; k++) begin
                @(negedge clock);
                if (rsp_valid != exp_grant || rsp_result != exp_res || rsp_error != exp_err ||
                    req_ready != '0 || fpu_input_rdy) stable_bad = 1'b1;
            end
            check({name, " backpressure_hold"}, 64'(stable_bad), 64'(0));
        end
        req_valid = '0;
        rsp_ack   = exp_grant;
        @(negedge clock);
        rsp_ack = '0;
        check({name, " release"}, 64'({rsp_valid, busy}), 64'(0));
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] b;
        logic [3:0]  exp_grant;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{4'b1111, 32'h000, 4'b0001, 32'h10000004};
        vecs[1]  = '{4'b1111, 32'h100, 4'b0010, 32'h20000106};
        vecs[2]  = '{4'b1111, 32'h200, 4'b0100, 32'h30000207};
        vecs[3]  = '{4'b1111, 32'h300, 4'b1000, 32'h40000308};
        vecs[4]  = '{4'b1111, 32'h400, 4'b0001, 32'h10000404};
        vecs[5]  = '{4'b1111, 32'h500, 4'b0010, 32'h20000506};
        vecs[6]  = '{4'b1111, 32'h600, 4'b0100, 32'h30000607};
        vecs[7]  = '{4'b1111, 32'h700, 4'b1000, 32'h40000708};
        vecs[8]  = '{4'b0100, 32'h800, 4'b0100, 32'h30000807};
        vecs[9]  = '{4'b0011, 32'h900, 4'b0001, 32'h10000904};
        vecs[10] = '{4'b1001, 32'hA00, 4'b1000, 32'h40000A08};
        vecs[11] = '{4'b0110, 32'hB00, 4'b0010, 32'h20000B06};
        vecs[12] = '{4'b0010, 32'hC00, 4'b0010, 32'h20000C06};
        vecs[13] = '{4'b1000, 32'hD00, 4'b1000, 32'h40000D08};

        set_data(32'h0);
        repeat (3) @(negedge clock);
        check_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        for (int k = 0; k < 14; k++) begin
            set_data(vecs[k].b);
            run_op($sformatf("rr%0d", k), vecs[k].mask, vecs[k].exp_grant, vecs[k].exp_result, 1'b0, 0);
        end

        set_data(32'h0);
        req_data_a[1*BITS +: BITS] = 32'h3F800000;
        req_data_b[1*BITS +: BITS] = 32'h40000000;
        req_command[1*4 +: 4]      = CMD_ADD;
        reply_delay = 3;
        oack_count  = 0;
        run_op("single", 4'b0010, 4'b0010, 32'h40400000, 1'b0, 0);
        check("single output_ack_cycles", 64'(oack_count), 64'(1));

        set_data(32'h0);
        reply_delay = 1;
        run_op("backpressure", 4'b0100, 4'b0100, 32'h30000007, 1'b0, 20);

        sticky = 5;
        drain_viol = 0;
        run_op("sticky", 4'b1000, 4'b1000, 32'h40000008, 1'b0, 0);
        sticky = 0;
        run_op("after_sticky", 4'b0001, 4'b0001, 32'h10000004, 1'b0, 0);
        check("sticky drain_violations", 64'(drain_viol), 64'(0));

        ack_enable = 0;
        irdy_count = 0;
        run_op("wd_issue", 4'b0010, 4'b0010, 32'h0, 1'b1, 0);
        check("wd_issue input_rdy_cycles", 64'(irdy_count), 64'(16));
        ack_enable = 1;

        reply_delay = 14;
        run_op("wd_collide", 4'b0100, 4'b0100, 32'h30000007, 1'b0, 0);

        reply_delay = 15;
        run_op("wd_wait", 4'b1000, 4'b1000, 32'h0, 1'b1, 0);
        model_flush = 1'b1;
        repeat (2) @(negedge clock);
        model_flush = 1'b0;

        reply_delay = 10;
        req_valid = 4'b0001;
        @(negedge clock);
        req_valid = '0;
        repeat (2) @(negedge clock);
        check("midreset in_wait", 64'({busy, fpu_input_rdy}), 64'(2'b10));
        reset = 1'b1;
        @(negedge clock);
        #1 check_zero_outputs("midreset");
        @(negedge clock);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 15; k++) begin
                @(negedge clock);
                if (rsp_valid != '0 || busy) seen++;
            end
            check("midreset no_response", 64'(seen), 64'(0));
        end
        reply_delay = 1;
        run_op("post_reset_ptr", 4'b1111, 4'b0001, 32'h10000004, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected completion");
        $fatal(1, "time limit");
    end

endmodule
